// File: rtl/match_ctrl.sv
// Game sequencer for the two-player tennis datapath: serve timing, lives,
// rally speed-up and game-over, driven by the ball/player return and miss pulses.
module match_ctrl #(
    parameter int LIVES       = 3,
    parameter int SERVE_DELAY = 50_000_000,
    parameter int RALLY_STEP  = 4,
    parameter int MAX_SPEED   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       return_one,
    input  logic       return_two,
    input  logic       miss_one,
    input  logic       miss_two,
    output logic       start_game,
    output logic       serve_side,
    output logic [3:0] lives_one,
    output logic [3:0] lives_two,
    output logic [2:0] speed_level,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    localparam int DW = $clog2(SERVE_DELAY + 1);
    localparam int CW = $clog2(RALLY_STEP + 1);

    localparam logic [DW-1:0] DELAY_LOAD = DW'(SERVE_DELAY - 1);
    localparam logic [CW-1:0] STEP_C     = CW'(RALLY_STEP);
    localparam logic [3:0]    LIVES_C    = 4'(LIVES);
    localparam logic [2:0]    SPEED_MAX  = 3'(MAX_SPEED);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_RALLY = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] delay_reg, delay_next;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] count_inc;
    logic [3:0]    lives_one_reg, lives_one_next;
    logic [3:0]    lives_two_reg, lives_two_next;
    logic [2:0]    speed_reg, speed_next;
    logic          serve_reg, serve_next;
    logic          winner_reg, winner_next;
    logic          start_game_reg, start_game_next;
    logic          game_over_reg, game_over_next;
    logic          loser_out;
    logic          any_return;

    // The player who just lost the point is always the one recorded as server.
    assign loser_out  = serve_reg ? (lives_two_reg == 4'd0) : (lives_one_reg == 4'd0);
    assign any_return = return_one | return_two;
    assign count_inc  = count_reg + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_btn) state_next = S_SERVE;
            S_SERVE: if (delay_reg == '0) state_next = S_RALLY;
            S_RALLY: begin
                if (miss_one && miss_two)     state_next = S_SERVE;
                else if (miss_one || miss_two) state_next = S_POINT;
            end
            S_POINT: state_next = loser_out ? S_OVER : S_SERVE;
            S_OVER:  if (start_btn) state_next = S_SERVE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        delay_next      = delay_reg;
        count_next      = count_reg;
        lives_one_next  = lives_one_reg;
        lives_two_next  = lives_two_reg;
        speed_next      = speed_reg;
        serve_next      = serve_reg;
        winner_next     = winner_reg;
        start_game_next = 1'b0;
        game_over_next  = (state_next == S_OVER);
        case (state_reg)
            S_IDLE: begin
                if (start_btn) begin
                    delay_next     = DELAY_LOAD;
                    lives_one_next = LIVES_C;
                    lives_two_next = LIVES_C;
                    serve_next     = 1'b0;
                    speed_next     = 3'd0;
                end
            end
            S_SERVE: begin
                if (delay_reg == '0) begin
                    start_game_next = 1'b1;
                    count_next      = '0;
                end else begin
                    delay_next = delay_reg - DW'(1);
                end
            end
            S_RALLY: begin
                // A miss outranks a same-cycle return; a double miss is a let.
                if (miss_one && miss_two) begin
                    delay_next = DELAY_LOAD;
                end else if (miss_one) begin
                    if (lives_one_reg != 4'd0) lives_one_next = lives_one_reg - 4'd1;
                    serve_next = 1'b0;
                end else if (miss_two) begin
                    if (lives_two_reg != 4'd0) lives_two_next = lives_two_reg - 4'd1;
                    serve_next = 1'b1;
                end else if (any_return) begin
                    if (count_inc == STEP_C) begin
                        count_next = '0;
                        if (speed_reg < SPEED_MAX) speed_next = speed_reg + 3'd1;
                    end else begin
                        count_next = count_inc;
                    end
                end
            end
            S_POINT: begin
                speed_next = 3'd0;
                count_next = '0;
                if (loser_out) begin
                    winner_next = ~serve_reg;
                end else begin
                    delay_next = DELAY_LOAD;
                end
            end
            S_OVER: begin
                if (start_btn) begin
                    lives_one_next = LIVES_C;
                    lives_two_next = LIVES_C;
                    speed_next     = 3'd0;
                    serve_next     = ~winner_reg;
                    delay_next     = DELAY_LOAD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            delay_reg      <= '0;
            count_reg      <= '0;
            lives_one_reg  <= LIVES_C;
            lives_two_reg  <= LIVES_C;
            speed_reg      <= 3'd0;
            serve_reg      <= 1'b0;
            winner_reg     <= 1'b0;
            start_game_reg <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            delay_reg      <= delay_next;
            count_reg      <= count_next;
            lives_one_reg  <= lives_one_next;
            lives_two_reg  <= lives_two_next;
            speed_reg      <= speed_next;
            serve_reg      <= serve_next;
            winner_reg     <= winner_next;
            start_game_reg <= start_game_next;
            game_over_reg  <= game_over_next;
        end
    end

    assign start_game  = start_game_reg;
    assign serve_side  = serve_reg;
    assign lives_one   = lives_one_reg;
    assign lives_two   = lives_two_reg;
    assign speed_level = speed_reg;
    assign game_over   = game_over_reg;
    assign winner      = winner_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized bench for match_ctrl: a game-level model queues the expected
// outcome of every serve and game-over; a monitor checks them as they appear.
module tb_match_ctrl;

    localparam int P_LIVES = 2;
    localparam int P_DELAY = 4;
    localparam int P_STEP  = 2;
    localparam int P_MAX   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_btn = 1'b0;
    logic       return_one = 1'b0;
    logic       return_two = 1'b0;
    logic       miss_one = 1'b0;
    logic       miss_two = 1'b0;
    logic       start_game;
    logic       serve_side;
    logic [3:0] lives_one;
    logic [3:0] lives_two;
    logic [2:0] speed_level;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    match_ctrl #(
        .LIVES(P_LIVES), .SERVE_DELAY(P_DELAY), .RALLY_STEP(P_STEP), .MAX_SPEED(P_MAX)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn),
        .return_one(return_one), .return_two(return_two),
        .miss_one(miss_one), .miss_two(miss_two),
        .start_game(start_game), .serve_side(serve_side),
        .lives_one(lives_one), .lives_two(lives_two),
        .speed_level(speed_level), .game_over(game_over),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit over;
        bit serve;
        int l1;
        int l2;
        int spd;
        bit win;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Game-level model state
    int m_lives[2];
    int m_serve;
    int m_base;
    int m_rets;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cur_speed();
        int s;
        s = m_base + m_rets / P_STEP;
        return (s > P_MAX) ? P_MAX : s;
    endfunction

    function automatic exp_t mk(input bit over, input int spd, input bit win);
        exp_t e;
        e.over  = over;
        e.serve = m_serve[0];
        e.l1    = m_lives[0];
        e.l2    = m_lives[1];
        e.spd   = spd;
        e.win   = win;
        return e;
    endfunction

    task automatic drive(input bit sb_i, input bit r1, input bit r2, input bit m1, input bit m2);
        @(negedge clk);
        start_btn = sb_i; return_one = r1; return_two = r2; miss_one = m1; miss_two = m2;
        @(posedge clk); #1;
        start_btn = 0; return_one = 0; return_two = 0; miss_one = 0; miss_two = 0;
    endtask

    task automatic wait_rally();
        int k = 0;
        while (state != 3'd2 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        check("reach_rally", int'(state), 2);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_start_game"}, int'(start_game), 0);
        check({tag, "_serve_side"}, int'(serve_side), 0);
        check({tag, "_lives_one"}, int'(lives_one), P_LIVES);
        check({tag, "_lives_two"}, int'(lives_two), P_LIVES);
        check({tag, "_speed"}, int'(speed_level), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
        check({tag, "_winner"}, int'(winner), 0);
    endtask

    task automatic start_match(input bit from_over);
        m_lives[0] = P_LIVES; m_lives[1] = P_LIVES;
        if (!from_over) m_serve = 0;
        m_base = 0; m_rets = 0;
        sb.push_back(mk(1'b0, 0, 1'b0));
        drive(1, 0, 0, 0, 0);
        check("start_to_serve", int'(state), 1);
        $display("[TB] start: serve_side=%0d lives=%0d/%0d", m_serve, m_lives[0], m_lives[1]);
    endtask

    // Monitor: pops expectations when a serve launches or the game ends.
    initial begin
        int  cyc = 0;
        int  entry = 0;
        bit  prev_sg = 0;
        bit  prev_go = 0;
        int  prev_st = 0;
        exp_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (state == 3'd1 && prev_st != 1) entry = cyc;
            if (start_game) begin
                check("sg_not_consecutive", int'(prev_sg), 0);
                check("sg_delay", cyc - entry, P_DELAY);
                check("sg_state_rally", int'(state), 2);
                if (sb.size() == 0) begin
                    check("sg_expected", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("sg_kind", 0, int'(e.over));
                    check("sg_serve_side", int'(serve_side), int'(e.serve));
                    check("sg_lives_one", int'(lives_one), e.l1);
                    check("sg_lives_two", int'(lives_two), e.l2);
                    check("sg_speed", int'(speed_level), e.spd);
                end
            end
            if (game_over && !prev_go) begin
                if (sb.size() == 0) begin
                    check("go_expected", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("go_kind", 1, int'(e.over));
                    check("go_winner", int'(winner), int'(e.win));
                    check("go_lives_one", int'(lives_one), e.l1);
                    check("go_lives_two", int'(lives_two), e.l2);
                    check("go_state", int'(state), 4);
                end
            end
            prev_sg = start_game;
            prev_go = game_over;
            prev_st = int'(state);
        end
    end

    initial begin
        int n, o, k, x;
        bit wret, r1, r2, sbt;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1;
        drive(0, 1, 1, 1, 1);
        check("idle_ignores_pulses", int'(state), 0);
        start_match(0);

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 4);
                drive(k == 0, k == 1, k == 2, k == 3, k == 4);
                check("serve_ignores_pulse", int'(state), 1);
            end
            wait_rally();
            n = (r == 0) ? 8 : $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 2);
                sbt = ($urandom_range(0, 5) == 0);
                drive(sbt, k != 1, k != 0, 0, 0);
                m_rets++;
                check("rally_speed", int'(speed_level), cur_speed());
                check("rally_state", int'(state), 2);
            end
            o = (r == 0) ? 1 : (r == 1) ? 2 : $urandom_range(0, 2);
            wret = (r == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            r1 = wret & 1'($urandom_range(0, 1));
            r2 = wret & ~r1;
            if (o == 2) begin
                m_base = cur_speed();
                m_rets = 0;
                sb.push_back(mk(1'b0, m_base, 1'b0));
                drive(0, r1, r2, 1, 1);
                check("let_state", int'(state), 1);
                $display("[TB] round %0d: let after %0d returns, speed=%0d", r, n, m_base);
            end else begin
                x = o;
                m_lives[x]--;
                m_serve = x;
                m_base = 0;
                m_rets = 0;
                if (m_lives[x] == 0) sb.push_back(mk(1'b1, 0, 1'(~x)));
                else                 sb.push_back(mk(1'b0, 0, 1'b0));
                drive(0, r1, r2, x == 0, x == 1);
                check("point_state", int'(state), 3);
                check(x == 0 ? "miss_lives_one" : "miss_lives_two",
                      x == 0 ? int'(lives_one) : int'(lives_two), m_lives[x]);
                $display("[TB] round %0d: miss by player %0d, lives=%0d/%0d", r, x + 1,
                         m_lives[0], m_lives[1]);
                @(posedge clk); #1;
                check("point_one_cycle", int'(state), m_lives[x] == 0 ? 4 : 1);
                if (m_lives[x] == 0) begin
                    drive(0, 1, 0, 1, 0);
                    check("over_holds", int'(game_over), 1);
                    $display("[TB] round %0d: game over, winner player %0d", r, 2 - x);
                    start_match(1);
                end
            end
        end

        // Reset during a serve countdown discards that serve.
        void'(sb.pop_back());
        check("pre_reset_serve", int'(state), 1);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        check_reset_state("midserve_reset");
        @(negedge clk);
        rst = 1;
        start_match(0);
        wait_rally();
        drive(1, 0, 0, 0, 0);
        check("rally_ignores_start", int'(state), 2);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
